// File: rtl/vga_pkg.sv
// Shared video-timing definitions: default 800x600@60 timing constants, the
// timing bundle handed to downstream draw stages, and a total-period helper.
package vga_pkg;

  localparam int unsigned CntW = 11;

  localparam int unsigned HActive = 800;
  localparam int unsigned HFp     = 40;
  localparam int unsigned HSync   = 128;
  localparam int unsigned HBp     = 88;
  localparam int unsigned HTotal  = HActive + HFp + HSync + HBp;

  localparam int unsigned VActive = 600;
  localparam int unsigned VFp     = 1;
  localparam int unsigned VSync   = 4;
  localparam int unsigned VBp     = 23;
  localparam int unsigned VTotal  = VActive + VFp + VSync + VBp;

  // Timing bundle passed along the draw_bg/draw_rect/draw_mouse pipeline.
  typedef struct packed {
    logic [CntW-1:0] hcount;
    logic [CntW-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } vga_timing_t;

  function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping position counter with registered blank/sync decode.
// Decodes are computed from the next count so they line up with count_o.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned ACTIVE = 800,
  parameter int unsigned FP     = 40,
  parameter int unsigned SYNC   = 128,
  parameter int unsigned BP     = 88,
  parameter logic        POL    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             blank_o,
  output logic             sync_o,
  output logic             blank_next_o
);

  localparam int unsigned      Total      = vga_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LastCnt    = CNT_W'(Total - 1);
  localparam logic [CNT_W-1:0] ActiveC    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SyncStartC = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SyncEndC   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_d, count_q;
  logic             blank_d, blank_q;
  logic             sync_d, sync_q;

  // Wrap is a next-state indication: the count returns to 0 at the coming edge.
  assign wrap_o = advance_i && (count_q == LastCnt);

  // Next count and the decodes that will accompany it.
  always_comb begin
    count_d = count_q;
    if (advance_i) begin
      count_d = wrap_o ? '0 : count_q + CNT_W'(1);
    end
    blank_d = (count_d >= ActiveC);
    sync_d  = ((count_d >= SyncStartC) && (count_d < SyncEndC)) ? POL : ~POL;
  end

  // Counter and decode registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      blank_q <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o      = count_q;
  assign blank_o      = blank_q;
  assign sync_o       = sync_q;
  assign blank_next_o = blank_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync/blank, data enable and
// line/frame start strobes, all registered and aligned with hcount/vcount.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W     = CntW,
  parameter int unsigned H_ACTIVE  = HActive,
  parameter int unsigned H_FP      = HFp,
  parameter int unsigned H_SYNC    = HSync,
  parameter int unsigned H_BP      = HBp,
  parameter int unsigned V_ACTIVE  = VActive,
  parameter int unsigned V_FP      = VFp,
  parameter int unsigned V_SYNC    = VSync,
  parameter int unsigned V_BP      = VBp,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int unsigned HTot = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTot = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint unsigned CntSpan = longint'(1) << CNT_W;

  if (longint'(HTot) > CntSpan || longint'(VTot) > CntSpan) begin : g_width_check
    $fatal(1, "vga_timing_gen: H or V total does not fit in CNT_W bits");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_check
    $fatal(1, "vga_timing_gen: timing parameters must all be non-zero");
  end

  logic h_wrap, v_wrap;
  logic h_blank_next, v_blank_next;

  vga_axis_cnt #(
    .CNT_W  (CNT_W),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_cnt (
    .clk_i        (clk),
    .rst_i        (rst),
    .advance_i    (ce),
    .count_o      (hcount),
    .wrap_o       (h_wrap),
    .blank_o      (hblnk),
    .sync_o       (hsync),
    .blank_next_o (h_blank_next)
  );

  // Vertical axis steps once per horizontal wrap, so vsync edges land on hcount=0.
  vga_axis_cnt #(
    .CNT_W  (CNT_W),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_cnt (
    .clk_i        (clk),
    .rst_i        (rst),
    .advance_i    (h_wrap),
    .count_o      (vcount),
    .wrap_o       (v_wrap),
    .blank_o      (vblnk),
    .sync_o       (vsync),
    .blank_next_o (v_blank_next)
  );

  logic de_d, de_q;
  logic line_start_d, line_start_q;
  logic frame_start_d, frame_start_q;

  // Data enable and strobes from next-state decodes; wraps already include ce.
  always_comb begin
    de_d          = ~h_blank_next & ~v_blank_next;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_wrap;
  end

  // Data enable and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_d, frame_cnt_q;

  // Frame counter bumps together with the frame_start strobe, wrapping freely.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: d0 default 800x600, d1 640x480 with low-active syncs,
// d2 a tiny 13x8 timing (hsync high, vsync low) so whole frames fit in the run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  always #5 clk = ~clk;

  logic [10:0] d0_hcount, d0_vcount, d1_hcount, d1_vcount;
  logic [3:0]  d2_hcount, d2_vcount;
  logic d0_hsync, d0_vsync, d0_hblnk, d0_vblnk, d0_de, d0_ls, d0_fs;
  logic d1_hsync, d1_vsync, d1_hblnk, d1_vblnk, d1_de, d1_ls, d1_fs;
  logic d2_hsync, d2_vsync, d2_hblnk, d2_vblnk, d2_de, d2_ls, d2_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d0_fc, d1_fc, d2_fc;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  vga_timing_gen u_d0 (
    .clk (clk), .rst (rst), .ce (ce), .hcount (d0_hcount), .vcount (d0_vcount),
    .hsync (d0_hsync), .vsync (d0_vsync), .hblnk (d0_hblnk), .vblnk (d0_vblnk),
    .de (d0_de), .line_start (d0_ls), .frame_start (d0_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt (d0_fc)
`endif
  );

  vga_timing_gen #(
    .CNT_W (11), .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (480), .V_FP (10), .V_SYNC (2), .V_BP (33),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) u_d1 (
    .clk (clk), .rst (rst), .ce (ce), .hcount (d1_hcount), .vcount (d1_vcount),
    .hsync (d1_hsync), .vsync (d1_vsync), .hblnk (d1_hblnk), .vblnk (d1_vblnk),
    .de (d1_de), .line_start (d1_ls), .frame_start (d1_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt (d1_fc)
`endif
  );

  // Tiny timing: H 6/2/3/2 (total 13), V 4/1/2/1 (total 8), frame = 104 clk.
  vga_timing_gen #(
    .CNT_W (4), .H_ACTIVE (6), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0)
  ) u_d2 (
    .clk (clk), .rst (rst), .ce (ce), .hcount (d2_hcount), .vcount (d2_vcount),
    .hsync (d2_hsync), .vsync (d2_vsync), .hblnk (d2_hblnk), .vblnk (d2_vblnk),
    .de (d2_de), .line_start (d2_ls), .frame_start (d2_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt (d2_fc)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    repeat (3) tick();
    n_chk++; if (d0_hcount !== 11'd0) $display("FAIL rst_hcount: got %0d want 0", d0_hcount); else n_pass++;
    n_chk++; if (d0_vcount !== 11'd0) $display("FAIL rst_vcount: got %0d want 0", d0_vcount); else n_pass++;
    n_chk++; if ({d0_hsync, d0_vsync} !== 2'b00) $display("FAIL rst_sync: got %b want 00", {d0_hsync, d0_vsync}); else n_pass++;
    n_chk++; if ({d0_hblnk, d0_vblnk} !== 2'b00) $display("FAIL rst_blnk: got %b want 00", {d0_hblnk, d0_vblnk}); else n_pass++;
    n_chk++; if (d0_de !== 1'b1) $display("FAIL rst_de: got %b want 1", d0_de); else n_pass++;
    n_chk++; if ({d0_ls, d0_fs} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {d0_ls, d0_fs}); else n_pass++;
    n_chk++; if ({d1_hsync, d1_vsync} !== 2'b11) $display("FAIL rst_sync_lowpol: got %b want 11", {d1_hsync, d1_vsync}); else n_pass++;
    n_chk++; if ({d2_hsync, d2_vsync} !== 2'b01) $display("FAIL rst_sync_mixpol: got %b want 01", {d2_hsync, d2_vsync}); else n_pass++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    n_chk++; if (d2_fc !== 16'd0) $display("FAIL rst_frame_cnt: got %0d want 0", d2_fc); else n_pass++;
`endif
    rst = 1'b0;
    tick();
    n_chk++; if (d0_hcount !== 11'd1) $display("FAIL first_step_h: got %0d want 1", d0_hcount); else n_pass++;
    n_chk++; if (d0_vcount !== 11'd0) $display("FAIL first_step_v: got %0d want 0", d0_vcount); else n_pass++;
    n_chk++; if (d2_hcount !== 4'd1) $display("FAIL first_step_tiny: got %0d want 1", d2_hcount); else n_pass++;
  endtask

  // Runs from hcount=1 until d0 wraps; d1 sweeps one full line plus part of the next.
  task automatic test_line_wrap();
    int hs_n = 0, hs_lo = -1, hs_hi = -1, hb_n = 0, hb_lo = -1;
    int ls_n = 0, ls_bad = 0, de_bad = 0, steps = 0;
    int d1_hs_n = 0, d1_lo = -1, d1_hi = -1, d1_ls_n = 0;
    bit wrapped = 1'b0;
    for (int i = 0; i < 1200 && !wrapped; i++) begin
      tick();
      steps++;
      if (d0_hsync) begin hs_n++; if (hs_lo < 0) hs_lo = int'(d0_hcount); hs_hi = int'(d0_hcount); end
      if (d0_hblnk) begin hb_n++; if (hb_lo < 0) hb_lo = int'(d0_hcount); end
      if (d0_ls) begin ls_n++; if (d0_hcount != 11'd0) ls_bad++; end
      if (d0_de !== ~(d0_hblnk | d0_vblnk)) de_bad++;
      if (!d1_hsync) begin d1_hs_n++; if (d1_lo < 0) d1_lo = int'(d1_hcount); d1_hi = int'(d1_hcount); end
      if (d1_ls) d1_ls_n++;
      if (d0_hcount == 11'd0) wrapped = 1'b1;
    end
    n_chk++; if (!wrapped) $display("FAIL line_wrap_timeout: got no wrap in %0d cycles want 1055", steps); else n_pass++;
    n_chk++; if (steps != 1055) $display("FAIL line_period: got %0d want 1055", steps); else n_pass++;
    n_chk++; if (d0_vcount !== 11'd1) $display("FAIL wrap_vcount: got %0d want 1", d0_vcount); else n_pass++;
    n_chk++; if (d0_ls !== 1'b1) $display("FAIL wrap_line_start: got %b want 1", d0_ls); else n_pass++;
    n_chk++; if (d0_fs !== 1'b0) $display("FAIL wrap_no_frame_start: got %b want 0", d0_fs); else n_pass++;
    n_chk++; if (hs_n != 128 || hs_lo != 840 || hs_hi != 967) $display("FAIL hsync_window: got n=%0d %0d..%0d want n=128 840..967", hs_n, hs_lo, hs_hi); else n_pass++;
    n_chk++; if (hb_n != 256 || hb_lo != 800) $display("FAIL hblnk_window: got n=%0d from %0d want n=256 from 800", hb_n, hb_lo); else n_pass++;
    n_chk++; if (ls_n != 1 || ls_bad != 0) $display("FAIL line_start_count: got n=%0d bad=%0d want n=1 bad=0", ls_n, ls_bad); else n_pass++;
    n_chk++; if (de_bad != 0) $display("FAIL de_consistency: got %0d bad cycles want 0", de_bad); else n_pass++;
    n_chk++; if (d1_hs_n != 96 || d1_lo != 656 || d1_hi != 751) $display("FAIL alt_hsync_window: got n=%0d %0d..%0d want n=96 656..751", d1_hs_n, d1_lo, d1_hi); else n_pass++;
    n_chk++; if (d1_ls_n != 1 || d1_vcount !== 11'd1 || d1_hcount !== 11'd256) $display("FAIL alt_line_800: got ls=%0d v=%0d h=%0d want ls=1 v=1 h=256", d1_ls_n, d1_vcount, d1_hcount); else n_pass++;
    tick();
    n_chk++; if (d0_ls !== 1'b0 || d0_hcount !== 11'd1) $display("FAIL line_start_width: got ls=%b h=%0d want ls=0 h=1", d0_ls, d0_hcount); else n_pass++;
  endtask

  // Two whole frames on the tiny timing.
  task automatic test_frame();
    int vs_n = 0, vs_lo = -1, vs_hi = -1, vb_bad = 0, hb_bad = 0, chg_bad = 0;
    int fs_n = 0, fs_bad = 0, fs_first = -1, fs_second = -1, ls_n = 0, hs_n = 0;
    int fc_first = -1;
    logic prev_vs;
    rst = 1'b1; ce = 1'b1;
    tick();
    rst = 1'b0;
    prev_vs = d2_vsync;
    for (int i = 1; i <= 208; i++) begin
      tick();
      if (!d2_vsync) begin vs_n++; if (vs_lo < 0) vs_lo = int'(d2_vcount); vs_hi = int'(d2_vcount); end
      if (d2_vblnk !== (d2_vcount >= 4'd4)) vb_bad++;
      if (d2_hblnk !== (d2_hcount >= 4'd6)) hb_bad++;
      if (d2_vsync !== prev_vs && d2_hcount != 4'd0) chg_bad++;
      prev_vs = d2_vsync;
      if (d2_hsync) hs_n++;
      if (d2_ls) ls_n++;
      if (d2_fs) begin
        fs_n++;
        if (d2_hcount != 4'd0 || d2_vcount != 4'd0) fs_bad++;
        if (fs_first < 0) begin
          fs_first = i;
`ifdef VGA_TIMING_FRAME_CNT_EN
          fc_first = int'(d2_fc);
`endif
        end else fs_second = i;
      end
    end
    n_chk++; if (vs_n != 52 || vs_lo != 5 || vs_hi != 6) $display("FAIL vsync_window: got n=%0d %0d..%0d want n=52 5..6", vs_n, vs_lo, vs_hi); else n_pass++;
    n_chk++; if (vb_bad != 0 || hb_bad != 0) $display("FAIL blank_decode: got vbad=%0d hbad=%0d want 0 0", vb_bad, hb_bad); else n_pass++;
    n_chk++; if (chg_bad != 0) $display("FAIL vsync_edge_align: got %0d edges off hcount 0 want 0", chg_bad); else n_pass++;
    n_chk++; if (hs_n != 48) $display("FAIL tiny_hsync_count: got %0d want 48", hs_n); else n_pass++;
    n_chk++; if (ls_n != 16) $display("FAIL tiny_line_count: got %0d want 16", ls_n); else n_pass++;
    n_chk++; if (fs_n != 2 || fs_bad != 0) $display("FAIL frame_start_count: got n=%0d bad=%0d want n=2 bad=0", fs_n, fs_bad); else n_pass++;
    n_chk++; if (fs_first != 104 || fs_second != 208) $display("FAIL frame_period: got %0d,%0d want 104,208", fs_first, fs_second); else n_pass++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    n_chk++; if (fc_first != 1) $display("FAIL frame_cnt_first: got %0d want 1", fc_first); else n_pass++;
    n_chk++; if (d2_fc !== 16'd2) $display("FAIL frame_cnt_second: got %0d want 2", d2_fc); else n_pass++;
`else
    if (fc_first != -1) $display("FAIL frame_cnt_absent: got %0d want -1", fc_first);
`endif
  endtask

  // ce alternating 1,0 on the tiny timing: line period doubles to 26 clk.
  task automatic test_ce_gating();
    int hold_bad = 0, ls_n = 0, ls_first = -1, ls_second = -1, ls_on_idle = 0;
    logic [15:0] prev;
    rst = 1'b1; ce = 1'b1;
    tick();
    rst = 1'b0;
    prev = {d2_hcount, d2_vcount, d2_hsync, d2_vsync, d2_hblnk, d2_vblnk, d2_de, 1'b0};
    for (int i = 1; i <= 64; i++) begin
      ce = (i % 2 == 1);
      tick();
      if (!ce) begin
        if ({d2_hcount, d2_vcount, d2_hsync, d2_vsync, d2_hblnk, d2_vblnk, d2_de, 1'b0} !== prev) hold_bad++;
        if (d2_ls || d2_fs) ls_on_idle++;
      end
      if (d2_ls) begin
        ls_n++;
        if (ls_first < 0) ls_first = i; else ls_second = i;
      end
      prev = {d2_hcount, d2_vcount, d2_hsync, d2_vsync, d2_hblnk, d2_vblnk, d2_de, 1'b0};
    end
    ce = 1'b1;
    n_chk++; if (hold_bad != 0) $display("FAIL ce_hold: got %0d changed idle cycles want 0", hold_bad); else n_pass++;
    n_chk++; if (ls_on_idle != 0) $display("FAIL ce_strobe_idle: got %0d want 0", ls_on_idle); else n_pass++;
    n_chk++; if (ls_n != 2 || ls_first != 25 || ls_second != 51) $display("FAIL ce_line_period: got n=%0d at %0d,%0d want n=2 at 25,51", ls_n, ls_first, ls_second); else n_pass++;
    n_chk++; if (d2_hcount !== 4'd6 || d2_vcount !== 4'd2) $display("FAIL ce_position: got h=%0d v=%0d want h=6 v=2", d2_hcount, d2_vcount); else n_pass++;
  endtask

  // Reset one edge before a frame wrap: reset must win and suppress the strobes.
  task automatic test_mid_reset();
    rst = 1'b1; ce = 1'b1;
    tick();
    rst = 1'b0;
    repeat (207) tick();
    n_chk++; if (d2_hcount !== 4'd12 || d2_vcount !== 4'd7) $display("FAIL pre_reset_pos: got h=%0d v=%0d want h=12 v=7", d2_hcount, d2_vcount); else n_pass++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    n_chk++; if (d2_fc !== 16'd1) $display("FAIL pre_reset_frame_cnt: got %0d want 1", d2_fc); else n_pass++;
`endif
    rst = 1'b1;
    tick();
    n_chk++; if (d2_hcount !== 4'd0 || d2_vcount !== 4'd0) $display("FAIL mid_rst_pos: got h=%0d v=%0d want 0 0", d2_hcount, d2_vcount); else n_pass++;
    n_chk++; if ({d2_ls, d2_fs} !== 2'b00) $display("FAIL mid_rst_strobes: got %b want 00", {d2_ls, d2_fs}); else n_pass++;
    n_chk++; if ({d2_hblnk, d2_vblnk, d2_de, d2_hsync, d2_vsync} !== 5'b00101) $display("FAIL mid_rst_levels: got %b want 00101", {d2_hblnk, d2_vblnk, d2_de, d2_hsync, d2_vsync}); else n_pass++;
    n_chk++; if (d0_hcount !== 11'd0 || d0_ls !== 1'b0) $display("FAIL mid_rst_d0: got h=%0d ls=%b want 0 0", d0_hcount, d0_ls); else n_pass++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    n_chk++; if (d2_fc !== 16'd0) $display("FAIL mid_rst_frame_cnt: got %0d want 0", d2_fc); else n_pass++;
`endif
    rst = 1'b0;
    tick();
    n_chk++; if (d2_hcount !== 4'd1 || d2_ls !== 1'b0) $display("FAIL post_rst_step: got h=%0d ls=%b want 1 0", d2_hcount, d2_ls); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_frame();
    test_ce_gating();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 VGA timing generator. Produces hcount/vcount, hsync/vsync, hblnk/vblnk, plus data-enable and frame/line start strobes.
- Timing, counter width and sync polarity are compile-time parameters.
- A pixel clock-enable allows running from a faster system clock.
- Sits at the head of the video pipeline and feeds the draw_bg/draw_rect/draw_mouse stages.

Parameters:
- CNT_W, 11, width of hcount/vcount.
- H_ACTIVE, 800, visible pixels per line.
- H_FP, 40, horizontal front porch.
- H_SYNC, 128, hsync width.
- H_BP, 88, horizontal back porch (H_TOTAL = sum = 1056).
- V_ACTIVE, 600, visible lines.
- V_FP, 1, vertical front porch.
- V_SYNC, 4, vsync width.
- V_BP, 23, vertical back porch (V_TOTAL = 628).
- HSYNC_POL, 1'b1, active level of hsync.
- VSYNC_POL, 1'b1, active level of vsync.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous active-high reset
- ce  in  1  pixel enable; counters advance only when 1
- hcount  out  CNT_W  horizontal position
- vcount  out  CNT_W  vertical position
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- de  out  1  active video = !hblnk & !vblnk
- line_start  out  1  one-cycle strobe when hcount becomes 0
- frame_start  out  1  one-cycle strobe when hcount and vcount both become 0

Behaviour:
- All outputs are registered and mutually consistent: every decode refers to the hcount/vcount values visible in the same cycle. Decodes are computed from next-state counts.
- Reset (synchronous, rst=1 at posedge), output values:
  - hcount=0, vcount=0.
  - hblnk=0, vblnk=0, de=1.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - line_start=0, frame_start=0.
- First ce=1 cycle after reset: hcount goes to 1. Position (0,0) is the reset state itself.
- Horizontal counting, on each posedge with ce=1:
  - hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1.
- Vertical counting: vcount increments only on the cycle hcount wraps H_TOTAL-1 -> 0. It wraps V_TOTAL-1 -> 0 the same way.
- ce=0: all counters and level outputs hold. Strobes are forced 0. Strobes last exactly one clk cycle, even when ce is sustained.
- Blanking and sync decodes:
  - hblnk=1 iff hcount >= H_ACTIVE.
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 840..967).
  - vblnk=1 iff vcount >= V_ACTIVE.
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 601..604). vsync changes coincide with hcount=0.
- line_start=1 in the cycle hcount transitions to 0. frame_start additionally requires vcount transitioning to 0.
- Reset mid-frame: the next cycle shows the full reset state, with no strobe emitted.
- Elaboration check: fatal error if H_TOTAL or V_TOTAL > 2**CNT_W, or if any porch/sync/active value is 0.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0].
  - Reset to 0.
  - Increments (wrapping 16'hFFFF -> 0) in the same cycle frame_start is asserted.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- vga_pkg: default timing constants (H_/V_ ACTIVE/FP/SYNC/BP and derived totals for 800x600@60), plus a packed struct vga_timing_t {hcount, vcount, hsync, vsync, hblnk, vblnk} for downstream stages.
- One sub-module: vga_axis_cnt, instantiated twice (horizontal and vertical). It is a generic wrapping counter with an advance input, a wrap output, and registered blank/sync decode parametrised by ACTIVE/FP/SYNC/BP/POL. The top level chains h.wrap into v.advance and forms de and the strobes.

Test Plan:
- Reset: hold rst 3 cycles, ce=1 → hcount=0, vcount=0, hsync=vsync=0, hblnk=vblnk=0, de=1. The next cycle gives hcount=1.
- Line wrap: after hcount=1055 → hcount=0, vcount+1, line_start=1 for exactly one cycle. hsync=1 exactly for hcount 840..967 (128 cycles). hblnk=1 for 800..1055.
- Frame: vblnk=1 for vcount 600..627. vsync=1 for vcount 601..604 (4×1056 cycles). Wrap 627→0 with frame_start=1. Frame period = 663168 cycles.
- ce gating: ce toggling 1,0 → counts advance every other cycle, outputs hold while ce=0, strobes stay one cycle wide. Line period = 2112 clk.
- Alt parameters: 640x480 (16/96/48, 10/2/33), HSYNC_POL=VSYNC_POL=0 → hsync low for hcount 656..751, vsync low for vcount 490..491, H_TOTAL=800, V_TOTAL=525.
- Mid-frame reset at hcount=500, vcount=300 → next cycle reset state, no strobes. With VGA_TIMING_FRAME_CNT_EN, frame_cnt=0, then 1 after the first frame wrap.
